// File: rtl/beat_timer_pkg.sv
// Shared types for the beat timer: sequencer state, T phase and machine-cycle encodings.
package beat_timer_pkg;

    localparam int T_DIV_DEF = 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} phase_t;

    // One-hot so the w1..w3 outputs come straight off the state flops
    typedef enum logic [2:0] {W1 = 3'b001, W2 = 3'b010, W3 = 3'b100} wcyc_t;

endpackage

// File: rtl/beat_timer_if.sv
// Control inputs and timing strobes of the beat timer, grouped as one bundle.
interface beat_timer_if #(parameter int CNT_W = 16);

    logic             qd;
    logic             step_mode;
    logic             stop;
    logic             short;
    logic             long;
    logic             t1, t2, t3, t4;
    logic             w1, w2, w3;
    logic             running;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output qd, step_mode, stop, short, long,
        input  t1, t2, t3, t4, w1, w2, w3, running, instr_done, instr_cnt
    );

    modport slave (
        input  qd, step_mode, stop, short, long,
        output t1, t2, t3, t4, w1, w2, w3, running, instr_done, instr_cnt
    );

endinterface

// File: rtl/beat_phase_ctr.sv
// T phase sequencer: holds each phase for T_DIV clks while enabled, then advances T1..T4.
module beat_phase_ctr
    import beat_timer_pkg::*;
#(
    parameter int T_DIV = T_DIV_DEF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] phase,
    output logic       phase_end
);

    logic [3:0] div;

    // Last clk of the current phase; only meaningful while the sequencer runs
    assign phase_end = en && (div == 4'(T_DIV - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            div   <= '0;
            phase <= '0;
        end else if (en) begin
            if (phase_end) begin
                div   <= '0;
                phase <= phase + 2'd1;
            end else begin
                div <= div + 4'd1;
            end
        end
    end

endmodule

// File: rtl/beat_timer.sv
// Instruction beat sequencer: T1..T4 phases inside W1/W2/W3 machine cycles, with
// single-step, stop and completed-instruction counting.
module beat_timer
    import beat_timer_pkg::*;
#(
    parameter int T_DIV = T_DIV_DEF,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          clr,
    beat_timer_if.slave   bus
);

    state_t           state, state_nxt;
    wcyc_t            wcyc, wcyc_nxt, w_after;
    phase_t           phase, phase_nxt;
    logic [1:0]       phase_raw;
    logic             phase_end;
    logic             t3_end, t4_end, completes;
    logic             s_short, s_long, s_stop;
    logic [3:0]       t_q, t_nxt;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    beat_phase_ctr #(.T_DIV(T_DIV)) u_phase (
        .clk       (clk),
        .clr       (clr),
        .en        (state == RUN),
        .phase     (phase_raw),
        .phase_end (phase_end)
    );

    assign phase  = phase_t'(phase_raw);
    assign t3_end = (state == RUN) && (phase == T3) && phase_end;
    assign t4_end = (state == RUN) && (phase == T4) && phase_end;

    // Machine cycle that follows the current one, from the flags captured at T3 end
    always_comb begin
        w_after = W1;
        unique case (wcyc)
            W1:      w_after = s_short ? W1 : W2;
            W2:      w_after = s_long  ? W3 : W1;
            default: w_after = W1;
        endcase
    end

    assign completes = t4_end && (w_after == W1);

    always_comb begin
        state_nxt = state;
        wcyc_nxt  = wcyc;
        case (state)
            IDLE: if (bus.qd) state_nxt = RUN;
            RUN: begin
                if (t4_end) begin
                    wcyc_nxt = w_after;
                    if (s_stop || (bus.step_mode && (w_after == W1)))
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        phase_nxt = phase_end ? phase_t'(phase_raw + 2'd1) : phase;
        // The divider is parked at T1 in IDLE, so leaving IDLE lights t1 first
        t_nxt     = (state_nxt == RUN) ? (4'b0001 << phase_nxt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            wcyc  <= W1;
        end else begin
            state <= state_nxt;
            wcyc  <= wcyc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            t_q     <= '0;
            s_short <= 1'b0;
            s_long  <= 1'b0;
            s_stop  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            t_q    <= t_nxt;
            done_q <= completes;
            if (t3_end) begin
                s_short <= bus.short;
                s_long  <= bus.long;
                s_stop  <= bus.stop;
            end
            if (completes)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.t1         = t_q[0];
    assign bus.t2         = t_q[1];
    assign bus.t3         = t_q[2];
    assign bus.t4         = t_q[3];
    assign bus.w1         = wcyc[0];
    assign bus.w2         = wcyc[1];
    assign bus.w3         = wcyc[2];
    assign bus.running    = (state == RUN);
    assign bus.instr_done = done_q;
    assign bus.instr_cnt  = cnt_q;

endmodule

// File: tb/tb_beat_timer.sv
// Directed bench for beat_timer: T_DIV=2 main instance plus a CNT_W=4, T_DIV=1 wrap instance.
module tb_beat_timer;

    logic clk = 1'b0;
    logic clr, clr4;
    int   errors = 0;
    int   checks = 0;

    beat_timer_if #(.CNT_W(16)) bus ();
    beat_timer_if #(.CNT_W(4))  bus4 ();

    beat_timer #(.T_DIV(2), .CNT_W(16)) dut  (.clk(clk), .clr(clr),  .bus(bus));
    beat_timer #(.T_DIV(1), .CNT_W(4))  dut4 (.clk(clk), .clr(clr4), .bus(bus4));

    always #5 clk = ~clk;

    // {running, t4..t1, w3..w1, instr_done}
    logic [8:0] outs;
    assign outs = {bus.running, bus.t4, bus.t3, bus.t2, bus.t1,
                   bus.w3, bus.w2, bus.w1, bus.instr_done};

    // Expected T strobe for clk c of a run started at c=0 with T_DIV=2
    function automatic logic [3:0] t_at(int c);
        return 4'(1 << ((c / 2) % 4));
    endfunction

    // Clear, then pulse qd; returns at the negedge of the first t1 clk (c=0)
    task automatic start;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; bus.qd = 1'b1;
        @(negedge clk); bus.qd = 1'b0;
    endtask

    task automatic test_reset;
        start();
        repeat (5) @(negedge clk);
        checks++;
        if (bus.running !== 1'b1) begin
            errors++; $display("FAIL reset_pre running got %b exp 1", bus.running);
        end
        clr = 1'b1; bus.qd = 1'b1;
        @(negedge clk);
        checks += 2;
        if (outs !== 9'b0_0000_001_0) begin
            errors++; $display("FAIL reset outs got %b exp %b", outs, 9'b0_0000_001_0);
        end
        if (bus.instr_cnt !== 16'd0) begin
            errors++; $display("FAIL reset cnt got %0d exp 0", bus.instr_cnt);
        end
        clr = 1'b0; bus.qd = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 9'b0_0000_001_0) begin
            errors++; $display("FAIL reset_qd_lost outs got %b exp %b", outs, 9'b0_0000_001_0);
        end
    endtask

    task automatic test_free_run;
        logic [8:0]  exp;
        logic [15:0] cexp;
        start();
        for (int c = 0; c < 50; c++) begin
            exp  = {1'b1, t_at(c), ((c / 8) % 2 == 1) ? 3'b010 : 3'b001, (c > 0 && c % 16 == 0)};
            cexp = 16'(c / 16);
            checks += 2;
            if (outs !== exp) begin
                errors++; $display("FAIL free_run outs c=%0d got %b exp %b", c, outs, exp);
            end
            if (bus.instr_cnt !== cexp) begin
                errors++; $display("FAIL free_run cnt c=%0d got %0d exp %0d", c, bus.instr_cnt, cexp);
            end
            bus.qd = (c == 20);
            @(negedge clk);
        end
    endtask

    task automatic test_long;
        logic [8:0]  exp;
        logic [2:0]  wexp;
        logic [15:0] cexp;
        start();
        for (int c = 0; c < 42; c++) begin
            wexp = (c < 8) ? 3'b001 : (c < 16) ? 3'b010 : (c < 24) ? 3'b100 :
                   (c < 32) ? 3'b001 : (c < 40) ? 3'b010 : 3'b001;
            exp  = {1'b1, t_at(c), wexp, (c == 24 || c == 40)};
            cexp = (c < 24) ? 16'd0 : (c < 40) ? 16'd1 : 16'd2;
            checks += 2;
            if (outs !== exp) begin
                errors++; $display("FAIL long outs c=%0d got %b exp %b", c, outs, exp);
            end
            if (bus.instr_cnt !== cexp) begin
                errors++; $display("FAIL long cnt c=%0d got %0d exp %0d", c, bus.instr_cnt, cexp);
            end
            if (c == 12) bus.long = 1'b1;
            if (c == 14) bus.long = 1'b0;
            @(negedge clk);
        end
    endtask

    // with_long also raises long in W1, which must not matter
    task automatic test_short(input logic with_long);
        logic [8:0]  exp;
        logic [15:0] cexp;
        start();
        for (int c = 0; c < 26; c++) begin
            exp  = {1'b1, t_at(c), (c >= 16 && c < 24) ? 3'b010 : 3'b001, (c == 8 || c == 24)};
            cexp = (c < 8) ? 16'd0 : (c < 24) ? 16'd1 : 16'd2;
            checks += 2;
            if (outs !== exp) begin
                errors++; $display("FAIL short(long=%0b) outs c=%0d got %b exp %b", with_long, c, outs, exp);
            end
            if (bus.instr_cnt !== cexp) begin
                errors++; $display("FAIL short(long=%0b) cnt c=%0d got %0d exp %0d", with_long, c, bus.instr_cnt, cexp);
            end
            if (c == 4) begin bus.short = 1'b1; bus.long = with_long; end
            if (c == 6) begin bus.short = 1'b0; bus.long = 1'b0; end
            @(negedge clk);
        end
    endtask

    task automatic test_stop;
        logic [8:0]  exp;
        logic [15:0] cexp;
        start();
        for (int c = 0; c < 22; c++) begin
            if (c < 8)       exp = {1'b1, t_at(c), 3'b001, 1'b0};
            else if (c < 12) exp = {1'b0, 4'b0000, 3'b010, 1'b0};
            else             exp = {1'b1, t_at(c - 12), (c < 20) ? 3'b010 : 3'b001, (c == 20)};
            cexp = (c < 20) ? 16'd0 : 16'd1;
            checks += 2;
            if (outs !== exp) begin
                errors++; $display("FAIL stop outs c=%0d got %b exp %b", c, outs, exp);
            end
            if (bus.instr_cnt !== cexp) begin
                errors++; $display("FAIL stop cnt c=%0d got %0d exp %0d", c, bus.instr_cnt, cexp);
            end
            bus.stop = (c == 4 || c == 5);
            bus.qd   = (c == 11);
            @(negedge clk);
        end
    endtask

    task automatic test_step;
        logic [8:0]  exp;
        logic [15:0] cexp;
        logic        run;
        int          b;
        bus.step_mode = 1'b1;
        start();
        for (int c = 0; c < 36; c++) begin
            run  = (c < 16) || (c >= 18 && c < 34);
            b    = (c < 18) ? c : c - 18;
            exp  = {run, run ? t_at(b) : 4'b0000, (run && b >= 8) ? 3'b010 : 3'b001, (c == 16 || c == 34)};
            cexp = (c < 16) ? 16'd0 : (c < 34) ? 16'd1 : 16'd2;
            checks += 2;
            if (outs !== exp) begin
                errors++; $display("FAIL step outs c=%0d got %b exp %b", c, outs, exp);
            end
            if (bus.instr_cnt !== cexp) begin
                errors++; $display("FAIL step cnt c=%0d got %0d exp %0d", c, bus.instr_cnt, cexp);
            end
            bus.qd = (c == 17);
            @(negedge clk);
        end
        bus.step_mode = 1'b0;
    endtask

    task automatic test_clr_mid;
        start();
        for (int c = 0; c < 27; c++) begin
            if (c == 16) begin
                checks++;
                if (bus.instr_cnt !== 16'd1 || bus.instr_done !== 1'b1) begin
                    errors++; $display("FAIL clr_mid pre cnt/done got %0d/%b exp 1/1", bus.instr_cnt, bus.instr_done);
                end
            end
            if (c == 26) begin
                checks++;
                if (outs !== {1'b1, 4'b0010, 3'b010, 1'b0}) begin
                    errors++; $display("FAIL clr_mid w2t2 outs got %b exp %b", outs, {1'b1, 4'b0010, 3'b010, 1'b0});
                end
                clr = 1'b1;
            end
            @(negedge clk);
        end
        checks += 2;
        if (outs !== 9'b0_0000_001_0) begin
            errors++; $display("FAIL clr_mid outs got %b exp %b", outs, 9'b0_0000_001_0);
        end
        if (bus.instr_cnt !== 16'd0) begin
            errors++; $display("FAIL clr_mid cnt got %0d exp 0", bus.instr_cnt);
        end
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.running !== 1'b0) begin
            errors++; $display("FAIL clr_mid stays_idle running got %b exp 0", bus.running);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] cexp;
        @(negedge clk); clr4 = 1'b1;
        @(negedge clk); clr4 = 1'b0; bus4.qd = 1'b1;
        @(negedge clk); bus4.qd = 1'b0;
        for (int c = 0; c < 131; c++) begin
            cexp = 4'((c / 8) % 16);
            checks += 2;
            if (bus4.instr_cnt !== cexp) begin
                errors++; $display("FAIL wrap cnt c=%0d got %0d exp %0d", c, bus4.instr_cnt, cexp);
            end
            if (bus4.instr_done !== (c > 0 && c % 8 == 0)) begin
                errors++; $display("FAIL wrap done c=%0d got %b exp %b", c, bus4.instr_done, (c > 0 && c % 8 == 0));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clr = 1'b1; clr4 = 1'b1;
        bus.qd = 1'b0; bus.step_mode = 1'b0; bus.stop = 1'b0; bus.short = 1'b0; bus.long = 1'b0;
        bus4.qd = 1'b0; bus4.step_mode = 1'b0; bus4.stop = 1'b0; bus4.short = 1'b0; bus4.long = 1'b0;
        test_reset();
        test_free_run();
        test_long();
        test_short(1'b0);
        test_short(1'b1);
        test_stop();
        test_step();
        test_clr_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
